// File: rtl/contador_param.sv
// contador_param: cascadable up/down/down-STEP counter with parallel load (macro CONTADOR_SAT_EN selects saturating arithmetic).
// Latency: one clk edge from enable/mode/cin/D to Q, rco and load; all outputs registered.
// Backpressure: none; cin gates counting so rco of one stage drives cin of the next.
module contador_param #(
   parameter int WIDTH = 4,
   parameter int STEP  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             cin,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic             rco,
   output logic             load
);

   localparam logic [1:0] MODE_UP    = 2'b00;
   localparam logic [1:0] MODE_DN1   = 2'b01;
   localparam logic [1:0] MODE_DNS   = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   // The extra top bit carries the carry (up) or borrow (down) out of the count.
   localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
   localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

   logic [WIDTH:0]   q_ext;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   sum_dn1;
   logic [WIDTH:0]   sum_dns;
   logic [WIDTH:0]   res;
   logic             wrap;
   logic [WIDTH-1:0] q_nxt;
   logic             rco_nxt;
   logic             load_nxt;

   assign q_ext   = {1'b0, Q};
   assign sum_up  = q_ext + ONE_EXT;
   assign sum_dn1 = q_ext - ONE_EXT;
   // Borrow bit is set exactly when Q < STEP, since both operands fit in WIDTH bits.
   assign sum_dns = q_ext - STEP_EXT;

   // Pick the arithmetic result for the current counting mode.
   always_comb begin
      res = sum_up;
      case (mode)
         MODE_DN1: res = sum_dn1;
         MODE_DNS: res = sum_dns;
         default:  res = sum_up;
      endcase
   end

   assign wrap = res[WIDTH];

   // Next-state decode: load wins over counting, cin gates counting only.
   always_comb begin
      q_nxt    = Q;
      rco_nxt  = 1'b0;
      load_nxt = 1'b0;
      if (enable) begin
         if (mode == MODE_LOAD) begin
            q_nxt    = D;
            load_nxt = 1'b1;
         end else if (cin) begin
            rco_nxt = wrap;
`ifdef CONTADOR_SAT_EN
            // Clamp at the limit instead of wrapping; rco stays high while clamped.
            if (wrap) begin
               q_nxt = (mode == MODE_UP) ? '1 : '0;
            end else begin
               q_nxt = res[WIDTH-1:0];
            end
`else
            q_nxt = res[WIDTH-1:0];
`endif
         end
      end
   end

   // State register; reset clears everything immediately and overrides any request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Q    <= '0;
         rco  <= 1'b0;
         load <= 1'b0;
      end else begin
         Q    <= q_nxt;
         rco  <= rco_nxt;
         load <= load_nxt;
      end
   end

endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: directed checks of contador_param (WIDTH=4, STEP=3) plus a two-stage cascade.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
// Saturating expectations are selected when CONTADOR_SAT_EN is defined.
module tb_contador_param;

   localparam int WIDTH = 4;
   localparam int STEP  = 3;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic             cin;
   logic [1:0]       mode;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             rco;
   logic             load;
   logic [WIDTH-1:0] q_hi;
   logic             rco_hi;
   logic             load_hi;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   contador_param #(.WIDTH(WIDTH), .STEP(STEP)) dut (
      .clk(clk), .reset(reset), .enable(enable), .cin(cin), .mode(mode),
      .D(D), .Q(Q), .rco(rco), .load(load)
   );

   // Upper stage of the cascade: cin fed from the lower stage's rco.
   contador_param #(.WIDTH(WIDTH), .STEP(STEP)) u_hi (
      .clk(clk), .reset(reset), .enable(enable), .cin(rco), .mode(mode),
      .D(D), .Q(q_hi), .rco(rco_hi), .load(load_hi)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; cin = 1'b0; mode = 2'b00; D = '0;
      #1;
      checks++;
      if ({Q, rco, load} !== {4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: Q=%h rco=%b load=%b, expected Q=0 rco=0 load=0", Q, rco, load);
      end
      tick();
      reset = 1'b0;
      enable = 1'b1; mode = 2'b11; D = 4'h9;
      tick();
      checks++;
      if ({Q, load} !== {4'h9, 1'b1}) begin
         errors++;
         $display("FAIL load9: Q=%h load=%b, expected Q=9 load=1", Q, load);
      end
      // Asynchronous reset mid-cycle, well before the next edge.
      enable = 1'b0;
      reset = 1'b1;
      #1;
      checks++;
      if ({Q, rco, load} !== {4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: Q=%h rco=%b load=%b, expected Q=0 rco=0 load=0", Q, rco, load);
      end
      #1;
      reset = 1'b0;
      enable = 1'b1; mode = 2'b00; cin = 1'b1;
      tick();
      checks++;
      if ({Q, rco, load} !== {4'h1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL first_edge_after_reset: Q=%h rco=%b load=%b, expected Q=1 rco=0 load=0", Q, rco, load);
      end
   endtask

   task automatic test_load_up();
      logic [3:0] eq [0:3];
      logic       er [0:3];
      logic       el [0:3];
`ifdef CONTADOR_SAT_EN
      eq = '{4'hE, 4'hF, 4'hF, 4'hF};
      er = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
      eq = '{4'hE, 4'hF, 4'h0, 4'h1};
      er = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
      el = '{1'b1, 1'b0, 1'b0, 1'b0};
      enable = 1'b1; cin = 1'b0; mode = 2'b11; D = 4'hE;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({Q, rco, load} !== {eq[i], er[i], el[i]}) begin
            errors++;
            $display("FAIL load_up[%0d]: Q=%h rco=%b load=%b, expected Q=%h rco=%b load=%b",
                     i, Q, rco, load, eq[i], er[i], el[i]);
         end
         mode = 2'b00; cin = 1'b1;
      end
   endtask

   task automatic test_down_step();
      logic [3:0] eq [0:3];
      logic       er [0:3];
`ifdef CONTADOR_SAT_EN
      eq = '{4'h4, 4'h1, 4'h0, 4'h0};
      er = '{1'b0, 1'b0, 1'b1, 1'b1};
`else
      eq = '{4'h4, 4'h1, 4'hE, 4'hB};
      er = '{1'b0, 1'b0, 1'b1, 1'b0};
`endif
      enable = 1'b1; mode = 2'b11; D = 4'h4; cin = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({Q, rco} !== {eq[i], er[i]}) begin
            errors++;
            $display("FAIL down_step[%0d]: Q=%h rco=%b, expected Q=%h rco=%b", i, Q, rco, eq[i], er[i]);
         end
         mode = 2'b10;
      end
   endtask

   task automatic test_down_cin();
      logic [3:0] eq [0:3];
      logic       er [0:3];
      logic       cv [0:3];
`ifdef CONTADOR_SAT_EN
      eq = '{4'h1, 4'h0, 4'h0, 4'h0};
`else
      eq = '{4'h1, 4'h0, 4'h0, 4'hF};
`endif
      er = '{1'b0, 1'b0, 1'b0, 1'b1};
      cv = '{1'b0, 1'b1, 1'b0, 1'b1};
      enable = 1'b1; mode = 2'b11; D = 4'h1; cin = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({Q, rco, load} !== {eq[i], er[i], (i == 0) ? 1'b1 : 1'b0}) begin
            errors++;
            $display("FAIL down_cin[%0d]: Q=%h rco=%b load=%b, expected Q=%h rco=%b",
                     i, Q, rco, load, eq[i], er[i]);
         end
         mode = 2'b01;
         if (i < 3) cin = cv[i + 1];
      end
   endtask

   task automatic test_enable_hold();
      logic [3:0] wrapq;
`ifdef CONTADOR_SAT_EN
      wrapq = 4'hF;
`else
      wrapq = 4'h0;
`endif
      enable = 1'b1; mode = 2'b11; D = 4'hF; cin = 1'b1;
      tick();
      enable = 1'b0; mode = 2'b00;
      tick();
      checks++;
      if ({Q, rco, load} !== {4'hF, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL hold_after_load: Q=%h rco=%b load=%b, expected Q=f rco=0 load=0", Q, rco, load);
      end
      enable = 1'b1;
      tick();
      checks++;
      if ({Q, rco} !== {wrapq, 1'b1}) begin
         errors++;
         $display("FAIL wrap_up: Q=%h rco=%b, expected Q=%h rco=1", Q, rco, wrapq);
      end
      enable = 1'b0;
      tick();
      checks++;
      if ({Q, rco, load} !== {wrapq, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL hold_after_wrap: Q=%h rco=%b load=%b, expected Q=%h rco=0 load=0", Q, rco, load, wrapq);
      end
   endtask

   task automatic test_reset_dominates();
      enable = 1'b1; mode = 2'b11; D = 4'hA; cin = 1'b1;
      reset = 1'b1;
      tick();
      checks++;
      if ({Q, rco, load} !== {4'h0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_over_load: Q=%h rco=%b load=%b, expected Q=0 rco=0 load=0", Q, rco, load);
      end
      reset = 1'b0;
      tick();
      checks++;
      if ({Q, load} !== {4'hA, 1'b1}) begin
         errors++;
         $display("FAIL load_after_reset: Q=%h load=%b, expected Q=a load=1", Q, load);
      end
   endtask

   task automatic test_cascade();
      reset = 1'b1;
      #1;
      reset = 1'b0;
      enable = 1'b1; mode = 2'b00; cin = 1'b1;
      repeat (17) tick();
      checks++;
      if ({q_hi, Q} !== 8'd17) begin
         errors++;
         $display("FAIL cascade_17: value=%0d, expected 17", {q_hi, Q});
      end
      repeat (283) tick();
      checks++;
      if ({q_hi, Q} !== 8'd44) begin
         errors++;
         $display("FAIL cascade_300: value=%0d, expected 44", {q_hi, Q});
      end
      checks++;
      if ({rco_hi, load_hi} !== 2'b00) begin
         errors++;
         $display("FAIL cascade_hi_flags: rco_hi=%b load_hi=%b, expected 0 0", rco_hi, load_hi);
      end
   endtask

`ifdef CONTADOR_SAT_EN
   task automatic test_sat();
      logic [3:0] eq [0:4];
      logic       er [0:4];
      eq = '{4'hE, 4'hF, 4'hF, 4'hF, 4'hF};
      er = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      enable = 1'b1; mode = 2'b11; D = 4'hE; cin = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if ({Q, rco} !== {eq[i], er[i]}) begin
            errors++;
            $display("FAIL sat_up[%0d]: Q=%h rco=%b, expected Q=%h rco=%b", i, Q, rco, eq[i], er[i]);
         end
         mode = 2'b00;
      end
   endtask
`endif

   initial begin
      test_reset();
      test_load_up();
      test_down_step();
      test_down_cin();
      test_enable_hold();
      test_reset_dominates();
`ifdef CONTADOR_SAT_EN
      test_sat();
`else
      test_cascade();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/contador_param.md
CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 Parameter STEP, default 3, decrement amount for mode 2'b10; legal range 1..2^WIDTH-1.
REQ-003 Port clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port enable  input  1  count/load enable, sampled at clk rising edge.
REQ-006 Port cin  input  1  cascade enable; the counter advances only when enable=1 and cin=1.
REQ-007 Port mode  input  2  operation select: 00 up-1, 01 down-1, 10 down-STEP, 11 parallel load.
REQ-008 Port D  input  WIDTH  parallel load value.
REQ-009 Port Q  output  WIDTH  registered count value.
REQ-010 Port rco  output  1  registered ripple-carry/borrow pulse; drives cin of the next stage.
REQ-011 Port load  output  1  registered flag; high for the cycle after a load is performed.

Function
REQ-012 All outputs SHALL be registered; a mode or enable change takes effect at the next clk rising edge (latency 1).
REQ-013 When enable=0, Q SHALL hold; rco and load SHALL be 0 on the next edge.
REQ-014 Mode 11 SHALL load Q<=D, set load<=1 and rco<=0, regardless of cin.
REQ-015 In modes 00/01/10 with cin=0, Q SHALL hold, and rco and load SHALL be 0.
REQ-016 Mode 00 with cin=1 SHALL set Q<=Q+1 modulo 2^WIDTH; rco<=1 only when Q was 2^WIDTH-1.
REQ-017 Mode 01 with cin=1 SHALL set Q<=Q-1 modulo 2^WIDTH; rco<=1 only when Q was 0.
REQ-018 Mode 10 with cin=1 SHALL set Q<=Q-STEP modulo 2^WIDTH; rco<=1 only when Q<STEP before the update.
REQ-019 In modes 00/01/10, load SHALL be 0.
REQ-020 rco SHALL be a single-cycle pulse per wrap event; back-to-back wraps produce back-to-back pulses.
REQ-021 All arithmetic SHALL be performed in WIDTH+1 bits; the extra bit is the carry/borrow and is never visible on Q.
REQ-022 A multi-stage cascade (rco of stage n to cin of stage n+1, shared clk/reset/enable/mode) SHALL count as one wider counter in modes 00/01.

Reset
REQ-023 reset=1 SHALL immediately, without waiting for clk, force Q=0, rco=0 and load=0.
REQ-024 reset SHALL dominate all other inputs, including a load request in the same cycle.
REQ-025 After reset deasserts, the first clk rising edge SHALL operate normally, with no dead cycle.
REQ-026 Asserting reset mid-count or mid-load SHALL discard the pending operation.

Configuration
REQ-027 The macro CONTADOR_SAT_EN SHALL select saturating arithmetic when defined, and modulo (wrapping) arithmetic when not defined.
REQ-028 With CONTADOR_SAT_EN defined, modes 00/01/10 SHALL clamp Q at 2^WIDTH-1 (up) or 0 (down) instead of wrapping.
REQ-029 With CONTADOR_SAT_EN defined, rco SHALL be 1 on every enabled edge where clamping occurs, so it stays high while held at the limit.
REQ-030 Without CONTADOR_SAT_EN, REQ-016..REQ-018 apply unchanged; load behaviour is identical in both builds.

Verification (WIDTH=4, STEP=3 unless stated)
REQ-031 Scenario 1: reset pulse while Q=9 and clk idle -> Q=0, rco=0 and load=0 before the next clk edge.
REQ-032 Scenario 2: mode=11, D=4'hE, enable=1 for one edge, then mode=00, cin=1 for 3 edges -> Q: E, F, 0, 1; load=1 only in the first cycle; rco=1 only in the cycle Q becomes 0.
REQ-033 Scenario 3: load 4'h4, then mode=10 for 3 edges -> Q: 1, E, B; rco=1 only in the cycle Q becomes E.
REQ-034 Scenario 4: load 4'h1, then mode=01 with cin toggling 1,0,1 -> Q: 0, 0, F; rco pulses only on the 0->F edge.
REQ-035 Scenario 5: two WIDTH=4 stages cascaded, mode=00, run 300 edges from 0 -> combined {Q_hi,Q_lo} = 300 mod 256 = 44.
REQ-036 Scenario 6 (CONTADOR_SAT_EN): load 4'hE, then mode=00 for 4 edges -> Q: F, F, F, F; rco: 0, 1, 1, 1.
